// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: byte-serial load/store over an 8-bit memory port,
// followed by a registered single-cycle register-file write pulse.
module mem_wb_stage #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wreg,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_result,
    input  logic [3:0]            in_mem_op,
    input  logic [ADDR_W-1:0]     in_mem_addr,
    input  logic [XLEN-1:0]       in_store_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ready,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic [XLEN-1:0]       write_data
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_store;
    logic                  r_unsigned;
    logic                  r_wreg;
    logic [1:0]            r_idx;
    logic [1:0]            r_last_idx;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0]     r_base;
    logic [XLEN-1:0]       r_sdata;
    logic [23:0]           r_rbuf;

    logic                  w_accept;
    logic                  w_is_mem;
    logic                  w_is_store;
    logic                  w_is_unsigned;
    logic                  w_done;
    logic                  w_rd_write;
    logic [1:0]            w_last_idx;
    logic [1:0]            w_idx_inc;
    logic [XLEN-1:0]       w_load_val;

    assign in_ready = (r_state == IDLE);

    always_comb begin
        w_accept      = in_valid & in_ready;
        w_is_store    = in_mem_op inside {4'b1001, 4'b1010, 4'b1011};
        w_is_mem      = w_is_store | (in_mem_op inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101});
        w_is_unsigned = in_mem_op inside {4'b0100, 4'b0101};
        case (in_mem_op)
            4'b0010, 4'b0101, 4'b1010: w_last_idx = 2'd1;
            4'b0011, 4'b1011:          w_last_idx = 2'd3;
            default:                   w_last_idx = 2'd0;
        endcase

        w_idx_inc  = r_idx + 2'd1;
        w_done     = (r_state == ACCESS) & mem_ready & (r_idx == r_last_idx);
        w_rd_write = r_wreg & (r_rd != '0) & ~r_store;

        // The final byte is taken straight from mem_rdata so the write can issue on the completing edge.
        case (r_last_idx)
            2'd0:    w_load_val = {{(XLEN-8){mem_rdata[7] & ~r_unsigned}}, mem_rdata};
            2'd1:    w_load_val = {{(XLEN-16){mem_rdata[7] & ~r_unsigned}}, mem_rdata, r_rbuf[7:0]};
            default: w_load_val = {mem_rdata, r_rbuf};
        endcase

        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_accept & w_is_mem) w_state_nxt = ACCESS;
            ACCESS: if (w_done)              w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            r_store      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_wreg       <= 1'b0;
            r_idx        <= '0;
            r_last_idx   <= '0;
            r_rd         <= '0;
            r_base       <= '0;
            r_sdata      <= '0;
            r_rbuf       <= '0;
        end else begin
            write_enable <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept & w_is_mem) begin
                    r_store    <= w_is_store;
                    r_unsigned <= w_is_unsigned;
                    r_wreg     <= in_wreg;
                    r_rd       <= in_rd;
                    r_base     <= in_mem_addr;
                    r_sdata    <= in_store_data;
                    r_last_idx <= w_last_idx;
                    r_idx      <= '0;
                    r_rbuf     <= '0;
                    mem_req    <= 1'b1;
                    mem_we     <= w_is_store;
                    mem_addr   <= in_mem_addr;
                    mem_wdata  <= in_store_data[7:0];
                end else if (w_accept & in_wreg & (in_rd != '0)) begin
                    write_enable <= 1'b1;
                    write_addr   <= in_rd;
                    write_data   <= in_result;
                end
            end else if (mem_ready) begin
                case (r_idx)
                    2'd0:    r_rbuf[7:0]   <= mem_rdata;
                    2'd1:    r_rbuf[15:8]  <= mem_rdata;
                    2'd2:    r_rbuf[23:16] <= mem_rdata;
                    default: ;
                endcase
                if (w_done) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (w_rd_write) begin
                        write_enable <= 1'b1;
                        write_addr   <= r_rd;
                        write_data   <= w_load_val;
                    end
                end else begin
                    // Store data is shifted down so the next byte is always at [15:8].
                    r_idx     <= w_idx_inc;
                    mem_addr  <= r_base + ADDR_W'(w_idx_inc);
                    mem_wdata <= r_sdata[15:8];
                    r_sdata   <= r_sdata >> 8;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: transaction-level model of memory traffic and
// register writes, plus hand-computed literal checks on key results.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_wreg = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_result = '0;
    logic [3:0]  in_mem_op = '0;
    logic [31:0] in_mem_addr = '0;
    logic [31:0] in_store_data = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    always #5 clk = ~clk;

    mem_wb_stage #(.ADDR_W(32), .REG_ADDR_W(5), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wreg(in_wreg), .in_rd(in_rd),
        .in_result(in_result), .in_mem_op(in_mem_op), .in_mem_addr(in_mem_addr),
        .in_store_data(in_store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    // Model state: expected byte transfers of the current access and pending register writes
    int          outstanding = 0;
    int          xi = 0;
    int          wait_left = 0;
    int          stall_cfg = 0;
    logic [31:0] exp_addr [4];
    logic [7:0]  exp_wd [4];
    logic [7:0]  rbytes [4];
    logic        exp_we = 1'b0;
    logic        spurious = 1'b0;
    wr_t         wq [$];
    logic [4:0]  last_wa = '0;
    logic [31:0] last_wd = '0;
    logic [4:0]  seen_wa = '0;
    logic [31:0] seen_wd = '0;
    int          n_writes = 0;
    int          busy_cycles = 0;
    logic        acc_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [3:0] op, input logic [31:0] w);
        logic [31:0] r;
        case (op)
            4'b0001: r = 32'($signed(w[7:0]));
            4'b0010: r = 32'($signed(w[15:0]));
            4'b0100: r = w & 32'h0000_00FF;
            4'b0101: r = w & 32'h0000_FFFF;
            default: r = w;
        endcase
        return r;
    endfunction

    // Single compare process; also acts as the memory responder.
    always @(negedge clk) begin
        if (!rst) begin
            mem_ready = 1'b0;
        end else begin
            if (!in_ready) busy_cycles++;
            if (write_enable) begin
                n_writes++;
                seen_wa = write_addr;
                seen_wd = write_data;
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0d data=%0h required no write", write_addr, write_data);
                end else begin
                    chk("wr_addr", 32'(write_addr), 32'(wq[0].a));
                    chk("wr_data", write_data, wq[0].d);
                    last_wa = wq[0].a;
                    last_wd = wq[0].d;
                    void'(wq.pop_front());
                end
            end else begin
                chk("wr_addr_hold", 32'(write_addr), 32'(last_wa));
                chk("wr_data_hold", write_data, last_wd);
            end
            chkb("in_ready", in_ready, outstanding == 0);
            chkb("mem_req", mem_req, outstanding > 0);
            if (outstanding > 0) begin
                chk("mem_addr", mem_addr, exp_addr[xi]);
                chkb("mem_we", mem_we, exp_we);
                if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd[xi]));
                if (wait_left > 0) begin
                    mem_ready = 1'b0;
                    mem_rdata = 8'hEE;
                    wait_left--;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = rbytes[xi];
                    xi++;
                    outstanding--;
                    wait_left = stall_cfg;
                end
            end else begin
                mem_ready = spurious;
                mem_rdata = 8'h5A;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic wreg, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rw, input int stall);
        int  k;
        int  n;
        bit  ld;
        bit  st;
        wr_t e;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual in_ready=0 required 1");
            return;
        end
        acc_we        = write_enable;
        in_valid      = 1'b1;
        in_mem_op     = op;
        in_wreg       = wreg;
        in_rd         = rd;
        in_result     = res;
        in_mem_addr   = addr;
        in_store_data = sd;
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        in_rd         = 5'h1F;
        in_result     = 32'hBAD0_BAD0;
        in_mem_addr   = 32'hFFFF_0000;
        in_store_data = 32'h0BAD_0BAD;
        ld = op inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
        st = op inside {4'b1001, 4'b1010, 4'b1011};
        case (op)
            4'b0001, 4'b0100, 4'b1001: n = 1;
            4'b0010, 4'b0101, 4'b1010: n = 2;
            4'b0011, 4'b1011:          n = 4;
            default:                   n = 0;
        endcase
        for (int i = 0; i < n; i++) begin
            exp_addr[i] = addr + 32'(i);
            exp_wd[i]   = sd[8*i +: 8];
            rbytes[i]   = rw[8*i +: 8];
        end
        exp_we      = st;
        xi          = 0;
        wait_left   = 0;
        stall_cfg   = stall;
        outstanding = n;
        e.a = rd;
        if (ld && wreg && rd != 5'd0) begin
            e.d = load_val(op, rw);
            wq.push_back(e);
        end else if (!ld && !st && wreg && rd != 5'd0) begin
            e.d = res;
            wq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((outstanding > 0 || wq.size() > 0) && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (outstanding > 0 || wq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual outstanding=%0d pending_writes=%0d required 0", outstanding, wq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        int bc;
        int k;

        repeat (3) @(posedge clk);
        #1;
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chkb("rst_we", write_enable, 1'b0);
        chk("rst_wa", 32'(write_addr), 32'h0);
        chk("rst_wd", write_data, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chkb("rel_in_ready", in_ready, 1'b1);

        issue(4'b0000, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 0);
        chkb("alu_we", write_enable, 1'b1);
        chk("alu_wa", 32'(write_addr), 32'd5);
        chk("alu_wd", write_data, 32'h1234_5678);
        @(posedge clk);
        #1;
        chkb("alu_we_pulse", write_enable, 1'b0);

        bc = busy_cycles;
        issue(4'b0011, 1'b1, 5'd6, 32'hDEAD_0000, 32'h100, 32'h0, 32'h1234_5678, 0);
        wait_idle();
        chk("lw_busy_cycles", 32'(busy_cycles - bc), 32'd4);
        chk("lw_wa", 32'(seen_wa), 32'd6);
        chk("lw_wd", seen_wd, 32'h1234_5678);

        issue(4'b0001, 1'b1, 5'd10, 32'h0, 32'h300, 32'h0, 32'h0000_0080, 0);
        wait_idle();
        chk("lb_wd", seen_wd, 32'hFFFF_FF80);
        issue(4'b0100, 1'b1, 5'd11, 32'h0, 32'h300, 32'h0, 32'h0000_0080, 0);
        wait_idle();
        chk("lbu_wd", seen_wd, 32'h0000_0080);
        issue(4'b0010, 1'b1, 5'd12, 32'h0, 32'h302, 32'h0, 32'h0000_FF80, 0);
        wait_idle();
        chk("lh_wd", seen_wd, 32'hFFFF_FF80);
        issue(4'b0101, 1'b1, 5'd13, 32'h0, 32'h301, 32'h0, 32'h0000_8001, 1);
        wait_idle();
        chk("lhu_wd", seen_wd, 32'h0000_8001);

        nw = n_writes;
        issue(4'b1010, 1'b1, 5'd14, 32'h0, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'h0, 2);
        wait_idle();
        issue(4'b1011, 1'b1, 5'd15, 32'h0, 32'h400, 32'h1122_3344, 32'h0, 1);
        wait_idle();
        chk("store_no_write", 32'(n_writes - nw), 32'd0);

        spurious = 1'b1;
        nw = n_writes;
        issue(4'b0000, 1'b1, 5'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 0);
        issue(4'b0000, 1'b0, 5'd3, 32'hFACE_FACE, 32'h0, 32'h0, 32'h0, 0);
        issue(4'b0111, 1'b1, 5'd0, 32'h1111_1111, 32'h0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        chk("rd0_no_write", 32'(n_writes - nw), 32'd0);
        chk("rd0_wd_hold", write_data, 32'h0000_8001);
        spurious = 1'b0;

        nw = n_writes;
        issue(4'b0011, 1'b1, 5'd7, 32'h0, 32'h500, 32'h0, 32'hCAFE_BABE, 0);
        issue(4'b0010, 1'b1, 5'd8, 32'h0, 32'h600, 32'h0, 32'h0000_7FFF, 0);
        chkb("b2b_accept_in_pulse", acc_we, 1'b1);
        wait_idle();
        chk("b2b_writes", 32'(n_writes - nw), 32'd2);
        chk("b2b_wa", 32'(seen_wa), 32'd8);
        chk("b2b_wd", seen_wd, 32'h0000_7FFF);

        nw = n_writes;
        issue(4'b0011, 1'b1, 5'd9, 32'h0, 32'h200, 32'h0, 32'h5566_7788, 0);
        k = 0;
        while (xi < 2 && k < 50) begin
            @(posedge clk);
            k++;
        end
        chk("mid_reset_bytes", 32'(xi), 32'd2);
        #2;
        rst = 1'b0;
        outstanding = 0;
        wait_left = 0;
        xi = 0;
        wq.delete();
        last_wa = '0;
        last_wd = '0;
        #1;
        chkb("arst_mem_req", mem_req, 1'b0);
        chkb("arst_we", write_enable, 1'b0);
        chkb("arst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chkb("post_rst_in_ready", in_ready, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_no_write", 32'(n_writes - nw), 32'd0);
        chk("post_rst_wd", write_data, 32'h0);

        issue(4'b0000, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 0);
        wait_idle();
        chk("post_rst_alu_wa", 32'(seen_wa), 32'd31);
        chk("post_rst_alu_wd", seen_wd, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage.
- Accepts one retired-from-EX instruction at a time, performs any load/store over the byte-serial memory port, and formats load data (sign/zero extension).
- Drives the register file write port with a registered, single-cycle write pulse.
- Sits between the EX/MEM pipeline latch and the register file; its in_ready backpressures the pipeline.

Parameters:
ADDR_W, 32, memory byte-address width
REG_ADDR_W, 5, register index width
XLEN, 32, register/data width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  instruction offered by EX/MEM
in_ready  out  1  stage can accept this cycle
in_wreg  in  1  instruction writes rd
in_rd  in  REG_ADDR_W  destination register
in_result  in  XLEN  ALU result (written for non-load ops)
in_mem_op  in  4  0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; other codes = none
in_mem_addr  in  ADDR_W  effective address
in_store_data  in  XLEN  store source (rs2)
mem_req  out  1  byte request
mem_we  out  1  1 = write byte
mem_addr  out  ADDR_W  byte address
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte, valid when mem_ready=1
mem_ready  in  1  current byte transferred this cycle
write_enable  out  1  register file write strobe
write_addr  out  REG_ADDR_W  register file write index
write_data  out  XLEN  register file write data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, write_enable=0, write_addr=0, write_data=0. An access in flight is abandoned and no write is issued. in_ready is 1 from the first edge after release.
- States: IDLE, ACCESS. in_ready = (state==IDLE).
- Accept = in_valid & in_ready, sampled at clk posedge.
- IDLE, accepted non-memory op:
  - Next cycle: write_enable = in_wreg & (in_rd!=0), write_addr=in_rd, write_data=in_result.
  - Stays IDLE.
- IDLE, accepted load/store:
  - Latch op, rd, wreg, base address, store data.
  - byte_cnt = 1/2/4 for B/H/W; idx=0; go to ACCESS.
  - write_enable=0 next cycle.
- ACCESS, every cycle:
  - mem_req=1, mem_we=(store), mem_addr=base+idx (ADDR_W wrap-around), mem_wdata=store_data[8*idx+7:8*idx].
  - All outputs are registered and held stable until mem_ready.
- ACCESS, on mem_ready=1:
  - Load: capture mem_rdata into byte idx (little-endian).
  - idx increments.
  - When idx reaches byte_cnt-1 with mem_ready=1:
    - Load: the next cycle presents write_enable = wreg & (rd!=0), write_addr=rd, write_data = extended value. Byte/half loads sign-extend; LBU/LHU zero-extend.
    - Store: write_enable=0.
    - mem_req drops the next cycle; state returns to IDLE.
- Latency, with mem_ready=1 every cycle, accept edge E:
  - mem_req is high for N cycles after E.
  - Load write_enable pulse occurs in cycle E+N+1.
  - in_ready returns in the same cycle.
- Back-to-back: a new instruction may be accepted in the cycle write_enable pulses. write_enable is never high for two consecutive cycles for the same instruction.
- write_enable is a one-cycle pulse. write_addr and write_data hold their last values when write_enable=0.
- Misaligned addresses are permitted and handled byte-serially with no exception.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset release, then ALU op in_rd=5, in_result=0x1234_5678, in_wreg=1 → next cycle write_enable=1, write_addr=5, write_data=0x12345678 for exactly one cycle.
- LW at 0x100, mem_rdata 0x78,0x56,0x34,0x12 with mem_ready every cycle → mem_addr 0x100..0x103, in_ready=0 for 4 cycles, then write_data=0x12345678, rd written.
- LB of byte 0x80 → write_data=0xFFFF_FF80; LBU of same byte → 0x0000_0080; LH of 0x80,0xFF → 0xFFFF_FF80.
- SH at 0xFFFF_FFFF, store_data 0xAABB_CCDD, mem_ready gated low two cycles between bytes → mem_wdata 0xDD at addr 0xFFFFFFFF, then 0xCC at addr 0x0 (wrap). Address and data stay stable while waiting; write_enable never asserted.
- rst driven low mid-LW after 2 bytes → mem_req and write_enable drop immediately (asynchronously). After release, in_ready=1 and no register write occurs.
- ALU op with in_rd=0, in_wreg=1 → write_enable stays 0. Load accepted in the same cycle as a prior load's write pulse → both writes occur, in order.
